// File: rtl/lifo_fifo_buf_pkg.sv
// Shared definitions for the LIFO/FIFO buffer.
// Mode encodings and the depth helper used by the buffer and its RAM.
package lifo_fifo_buf_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/lifo_fifo_buf_stack_ram.sv
// Register-file storage for lifo_fifo_buf: one sync write, one async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Not reset.
module stack_ram
    import lifo_fifo_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = int'(depth_of(ADDR_W));

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buf.sv
// Parametrised push/pop buffer, runtime LIFO or FIFO, sticky of/uf flags.
// Ports: clk, reset, wr/rd/wr_data, mode, clr_err in;
//        rd_data, count, empty, full, of, uf, mode_q out.
module lifo_fifo_buf
    import lifo_fifo_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mode,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              of,
    output logic              uf,
    output logic              mode_q
);

    localparam logic [ADDR_W:0] FULL_CNT =
        (ADDR_W+1)'(depth_of(ADDR_W));

    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              mode_r;
    logic              of_q;
    logic              uf_q;

    logic              is_empty;
    logic              is_full;
    logic              both;
    logic              do_push;
    logic              do_pop;
    logic              of_ev;
    logic              uf_ev;
    logic              idle_load;
    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              we;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == FULL_CNT);

    // Replace-in-place: a combined push+pop on a non-empty buffer.
    assign both     = wr & rd & ~is_empty;
    // With rd also set the push always goes through: either it is a
    // replace, or the buffer is empty and only the pop is refused.
    assign do_push  = wr & (rd | ~is_full);
    assign do_pop   = rd & ~is_empty;
    assign of_ev    = wr & ~rd & is_full;
    assign uf_ev    = rd & is_empty;
    assign idle_load = is_empty & ~wr & ~rd;

    // Full wraps the low bits to 0, so minus one still lands on the top.
    assign top_idx = cnt_q[ADDR_W-1:0] - 1'b1;

    always_comb begin
        waddr = '0;
        raddr = '0;
        unique case (mode_r)
            MODE_LIFO: begin
                waddr = both ? top_idx : cnt_q[ADDR_W-1:0];
                raddr = top_idx;
            end
            MODE_FIFO: begin
                waddr = wr_ptr_q;
                raddr = rd_ptr_q;
            end
            default: begin
                waddr = '0;
                raddr = '0;
            end
        endcase
    end

    // Storage has no reset, so hold off the write while reset is high.
    assign we = do_push & ~reset;

    stack_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (do_push && !do_pop) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r   <= MODE_LIFO;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (idle_load) begin
            mode_r   <= mode;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (mode_r == MODE_FIFO) begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Clear first, then a same-cycle error event wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            of_q <= 1'b0;
            uf_q <= 1'b0;
        end else begin
            of_q <= (of_q & ~clr_err) | of_ev;
            uf_q <= (uf_q & ~clr_err) | uf_ev;
        end
    end

    assign rd_data = is_empty ? '0 : ram_rdata;
    assign count   = cnt_q;
    assign empty   = is_empty;
    assign full    = is_full;
    assign of      = of_q;
    assign uf      = uf_q;
    assign mode_q  = mode_r;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Self-checking bench for lifo_fifo_buf (DATA_W=8, ADDR_W=2).
// Queue model of contents feeds a scoreboard of expected outputs.
module tb_lifo_fifo_buf;

    logic       clk;
    logic       reset;
    logic       wr;
    logic       rd;
    logic [7:0] wr_data;
    logic       mode;
    logic       clr_err;
    logic [7:0] rd_data;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       of;
    logic       uf;
    logic       mode_q;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] head;
        int         cnt;
        logic       of;
        logic       uf;
        logic       mq;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m[$];
    logic       m_mq;
    logic       m_of;
    logic       m_uf;

    lifo_fifo_buf #(
        .DATA_W (8),
        .ADDR_W (2)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .wr_data (wr_data),
        .mode    (mode),
        .clr_err (clr_err),
        .rd_data (rd_data),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .of      (of),
        .uf      (uf),
        .mode_q  (mode_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_head();
        if (m.size() == 0) return 8'h00;
        return m_mq ? m[0] : m[m.size()-1];
    endfunction

    // Reference behaviour for one clock edge.
    task automatic model(input logic w, input logic r,
                         input logic [7:0] d, input logic c);
        int   n;
        logic oe;
        logic ue;
        exp_t e;
        n  = m.size();
        oe = 1'b0;
        ue = 1'b0;
        if (w && r) begin
            if (n == 0) begin
                ue = 1'b1;
                m.push_back(d);
            end else if (!m_mq) begin
                m[n-1] = d;
            end else begin
                void'(m.pop_front());
                m.push_back(d);
            end
        end else if (w) begin
            if (n == 4) oe = 1'b1;
            else m.push_back(d);
        end else if (r) begin
            if (n == 0) ue = 1'b1;
            else if (!m_mq) void'(m.pop_back());
            else void'(m.pop_front());
        end else if (n == 0) begin
            m_mq = mode;
        end
        m_of = (m_of & ~c) | oe;
        m_uf = (m_uf & ~c) | ue;
        e.head = m_head();
        e.cnt  = m.size();
        e.of   = m_of;
        e.uf   = m_uf;
        e.mq   = m_mq;
        sb.push_back(e);
    endtask

    task automatic op(input logic w, input logic r,
                      input logic [7:0] d, input logic c);
        exp_t e;
        wr      = w;
        rd      = r;
        wr_data = d;
        clr_err = c;
        model(w, r, d, c);
        @(posedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
        e = sb.pop_front();
        check("sb_head", 32'(rd_data), 32'(e.head));
        check("sb_count", 32'(count), 32'(e.cnt));
        check("sb_empty", 32'(empty), 32'(e.cnt == 0));
        check("sb_full", 32'(full), 32'(e.cnt == 4));
        check("sb_of", 32'(of), 32'(e.of));
        check("sb_uf", 32'(uf), 32'(e.uf));
        check("sb_mode_q", 32'(mode_q), 32'(e.mq));
    endtask

    task automatic push(input logic [7:0] d);
        op(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic pop();
        op(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic clr();
        op(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        wr_data = 8'h00;
        mode    = 1'b0;
        clr_err = 1'b0;
        m_mq    = 1'b0;
        m_of    = 1'b0;
        m_uf    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_flags", 32'({of, uf, mode_q}), 32'd0);
        reset = 1'b0;
        idle();

        // LIFO fill and overflow
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("lifo_full", 32'(full), 32'd1);
        check("lifo_top", 32'(rd_data), 32'h44);
        push(8'h66);
        check("of_set", 32'(of), 32'd1);
        check("of_head", 32'(rd_data), 32'h44);
        clr();
        check("of_clr", 32'(of), 32'd0);

        // replace on full LIFO
        op(1'b1, 1'b1, 8'h99, 1'b0);
        check("lifo_rep", 32'(rd_data), 32'h99);
        check("lifo_rep_cnt", 32'(count), 32'd4);
        check("lifo_rep_of", 32'(of), 32'd0);

        pop();
        check("lifo_pop1", 32'(rd_data), 32'h33);
        pop();
        pop();
        check("lifo_pop3", 32'(rd_data), 32'h11);
        pop();
        check("lifo_drain", 32'(rd_data), 32'h00);
        pop();
        check("uf_set", 32'(uf), 32'd1);
        clr();
        check("uf_clr", 32'({of, uf}), 32'd0);

        // push+pop on empty
        op(1'b1, 1'b1, 8'h55, 1'b0);
        check("empty_rw_cnt", 32'(count), 32'd1);
        check("empty_rw_data", 32'(rd_data), 32'h55);
        check("empty_rw_uf", 32'(uf), 32'd1);

        // clear coincident with overflow
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        op(1'b1, 1'b0, 8'hEE, 1'b1);
        check("clr_vs_of", 32'(of), 32'd1);
        check("clr_vs_uf", 32'(uf), 32'd0);
        clr();
        for (int i = 0; i < 4; i++) pop();

        // FIFO with pointer wrap
        mode = 1'b1;
        idle();
        check("fifo_mode", 32'(mode_q), 32'd1);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        check("fifo_head", 32'(rd_data), 32'hA0);
        pop();
        pop();
        push(8'hA4);
        push(8'hA5);
        check("fifo_wrap_cnt", 32'(count), 32'd4);
        check("fifo_wrap_h0", 32'(rd_data), 32'hA2);
        pop();
        check("fifo_wrap_h1", 32'(rd_data), 32'hA3);
        pop();
        pop();
        check("fifo_wrap_h3", 32'(rd_data), 32'hA5);
        pop();

        // replace on full FIFO
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        op(1'b1, 1'b1, 8'hB4, 1'b0);
        check("fifo_rep_cnt", 32'(count), 32'd4);
        check("fifo_rep_head", 32'(rd_data), 32'hB1);
        check("fifo_rep_of", 32'(of), 32'd0);
        pop();
        pop();

        // mode change held off while occupied
        mode = 1'b0;
        idle();
        check("guard_busy", 32'(mode_q), 32'd1);
        pop();
        pop();
        check("guard_drain", 32'(mode_q), 32'd1);
        idle();
        check("guard_load", 32'(mode_q), 32'd0);

        // async reset mid-burst
        pop();
        push(8'h61);
        push(8'h62);
        wr      = 1'b1;
        wr_data = 8'h63;
        #3;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_flags", 32'({of, uf, mode_q}), 32'd0);
        check("arst_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        wr    = 1'b0;
        reset = 1'b0;
        m.delete();
        m_mq = 1'b0;
        m_of = 1'b0;
        m_uf = 1'b0;
        @(posedge clk);
        #1;
        push(8'h77);
        check("arst_push", 32'(rd_data), 32'h77);
        check("arst_push_cnt", 32'(count), 32'd1);
        push(8'h78);
        pop();
        check("arst_idx0", 32'(rd_data), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
